sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
- Shares the single RW port of a 16x2 OpenRAM SRAM macro between two requesters, using round-robin arbitration.
- Each requester uses a valid/ready command interface and gets a private read-response channel.
- The block drives the macro's registered csb0/web0/addr0/din0 inputs and samples dout0 at the correct edge.
- Sits between client logic and the macro; one command per cycle of throughput.

Parameters:
- DATA_WIDTH, 2, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width (depth = 1<<ADDR_WIDTH).
- INIT_VALUE, 2'b00, word written by the init sweep (used only with SRAM_ARB_INIT_EN).

Ports:
- clk0  in  1  clock, shared with the SRAM macro.
- rst0  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  command address.
- req0_wdata  in  DATA_WIDTH  write data.
- rsp0_valid  out  1  read data valid for requester 0.
- rsp0_rdata  out  DATA_WIDTH  read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.
- init_busy  out  1  init sweep in progress (constant 0 without the macro).

Behaviour:
- Reset values (edge with rst0=1):
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - rsp*_valid=0, rsp*_rdata=0.
  - Round-robin pointer = requester 0.
  - FSM = INIT with the macro, RUN without it.
  - Any in-flight read is discarded: no rsp_valid after reset.
- Arbitration (combinational, RUN state only):
  - Only one valid: it is granted.
  - Both valid: the pointer's requester is granted.
  - reqN_ready = grantN. Ready never asserts without the matching valid.
  - Ready is 0 in INIT and while rst0=1.
  - Pointer moves to the other requester after every accepted command. No change on idle cycles.
- Command stage: on the acceptance edge t, the SRAM-side flops load:
  - csb0=0, web0=~we, addr, din.
  - With no acceptance, csb0=1; addr0/din0 hold their last values.
- The macro captures at edge t+1. Write data lands at the negedge of that cycle.
- Read tracking: a 2-stage shift of {is_read, requester id} follows each command. At edge t+2:
  - rspN_rdata <= sram_dout0.
  - rspN_valid=1 for exactly one cycle.
  - sram_dout0 is sampled at that posedge, before the macro's hold-to-X time.
- Read latency is exactly 2 cycles from acceptance to rsp_valid. Writes produce no response.
- Back-to-back operation:
  - One command is accepted per cycle, so at most one rsp_valid (across both ports) is asserted per cycle.
  - A read of address A accepted the cycle after a write to A returns the new data.
  - rsp_valid has no backpressure; requesters must always accept it.
- Boundary conditions:
  - Addresses 0x0–0xF are all legal. No wrap logic is needed.
  - A requester holding valid continuously under contention is granted at least every other cycle.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN.
- Defined:
  - After reset the FSM enters INIT and issues 16 consecutive writes of INIT_VALUE to addresses 0..15, one per cycle, via the command stage.
  - init_busy=1 and both readys=0 throughout INIT.
  - After the address-15 write is issued, FSM goes to RUN and init_busy drops on the next edge.
  - Reset during INIT restarts the sweep at address 0.
- Undefined:
  - FSM resets straight to RUN and init_busy is tied 0.
  - SRAM contents are X until written.

Decomposition:
- Package sram_arb_pkg:
  - State enum {INIT, RUN}.
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - Requester-id type (1 bit).
  - Read-tracking entry struct {valid, is_read, id}.
- One sub-module, rr_arb2:
  - Inputs: 2 valids, enable, advance.
  - Outputs: one-hot grant.
  - Holds the pointer flop.

Test Plan:
- Reset released, then req0 writes A=3, D=2'b10, then req0 reads A=3.
  - sram_csb0=0/web0=0 one cycle after the write is accepted.
  - rsp0_valid=1 with rsp0_rdata=2'b10 exactly 2 cycles after the read is accepted.
- Both requesters valid with reads of addresses 1 and 2 for 4 cycles.
  - Grants alternate 0,1,0,1.
  - rsp0 and rsp1 valids alternate, with no cycle where both are asserted.
- Write A=5 D=01 immediately followed by a read of A=5, from different requesters.
  - Read returns 2'b01.
- Read accepted at edge t, rst0 pulsed at edge t+1.
  - No rsp_valid at t+2.
  - sram_csb0=1.
  - Pointer back to 0.
- With SRAM_ARB_INIT_EN, release reset with both valids high.
  - 16 writes of INIT_VALUE to 0..15 are issued; readys stay 0 until init_busy falls.
  - A subsequent read of address 15 returns 2'b00.
- req1 alone valid for 3 cycles.
  - Accepted every cycle; req0_ready stays 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int unsigned DataWidthDefault = 2;
  localparam int unsigned AddrWidthDefault = 4;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    logic    is_read;
    req_id_t id;
  } trk_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer favours the requester not served last.
module rr_arb2 (
  input  logic       clk0,
  input  logic       rst0,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
    ptr_d = ptr_q;
    // After serving requester 0 the pointer moves to 1, and vice versa.
    if (advance_i) ptr_d = grant_o[0];
  end

  always_ff @(posedge clk0) begin
    if (rst0) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one OpenRAM RW port between two valid/ready requesters; read data returns 2 cycles later.
// Optional power-on clear sweep enabled by defining SRAM_ARB_INIT_EN.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DataWidthDefault,
  parameter int unsigned           ADDR_WIDTH = AddrWidthDefault,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_busy
);

`ifdef SRAM_ARB_INIT_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StRun;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  issue;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  req_id_t               cmd_id;
  trk_entry_t            trk_d, trk0_q, trk1_q;
  logic                  rsp0_hit, rsp1_hit;

  rr_arb2 u_rr_arb2 (
    .clk0      (clk0),
    .rst0      (rst0),
    .valid_i   ({req1_valid, req0_valid}),
    .enable_i  (arb_en),
    .advance_i (|grant),
    .grant_o   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    arb_en      = 1'b0;
    issue       = 1'b0;
    cmd_we      = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cmd_id      = 1'b0;
    unique case (state_q)
      StInit: begin
        issue       = 1'b1;
        cmd_we      = 1'b1;
        cmd_addr    = init_addr_q;
        cmd_wdata   = INIT_VALUE;
        init_addr_d = init_addr_q + 1'b1;
        if (&init_addr_q) state_d = StRun;
      end
      StRun: begin
        arb_en    = ~rst0;
        issue     = |grant;
        cmd_id    = grant[1];
        cmd_we    = grant[1] ? req1_we : req0_we;
        cmd_addr  = grant[1] ? req1_addr : req0_addr;
        cmd_wdata = grant[1] ? req1_wdata : req0_wdata;
      end
      default: state_d = StRun;
    endcase

    trk_d         = '0;
    trk_d.valid   = issue;
    trk_d.is_read = issue & ~cmd_we;
    trk_d.id      = cmd_id;
  end

  assign rsp0_hit = trk1_q.valid & trk1_q.is_read & (trk1_q.id == 1'b0);
  assign rsp1_hit = trk1_q.valid & trk1_q.is_read & (trk1_q.id == 1'b1);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= ResetState;
      init_addr_q <= '0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      trk0_q      <= '0;
      trk1_q      <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_rdata  <= '0;
      rsp1_rdata  <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      sram_csb0   <= ~issue;
      sram_web0   <= ~(issue & cmd_we);
      if (issue) begin
        sram_addr0 <= cmd_addr;
        sram_din0  <= cmd_wdata;
      end
      trk0_q     <= trk_d;
      trk1_q     <= trk0_q;
      rsp0_valid <= rsp0_hit;
      rsp1_valid <= rsp1_hit;
      // dout0 is still stable here; the macro drives it from the preceding negedge.
      if (rsp0_hit) rsp0_rdata <= sram_dout0;
      if (rsp1_hit) rsp1_rdata <= sram_dout0;
    end
  end

`ifdef SRAM_ARB_INIT_EN
  assign init_busy = (state_q == StInit);
`else
  assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural 16x2 OpenRAM-style macro model.
module tb_sram_rr_arbiter;

`ifdef SRAM_ARB_INIT_EN
  localparam logic InitEn = 1'b1;
`else
  localparam logic InitEn = 1'b0;
`endif

  logic       clk0, rst0;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr;
  logic [1:0] req0_wdata;
  logic       rsp0_valid;
  logic [1:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr;
  logic [1:0] req1_wdata;
  logic       rsp1_valid;
  logic [1:0] rsp1_rdata;
  logic       sram_csb0, sram_web0;
  logic [3:0] sram_addr0;
  logic [1:0] sram_din0, sram_dout0;
  logic       init_busy;

  int n_checks = 0;
  int n_fails  = 0;

  sram_rr_arbiter dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .init_busy  (init_busy)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Macro model: inputs registered at posedge, read/write performed at the following negedge.
  logic [1:0] mem [16];
  logic       m_csb, m_web;
  logic [3:0] m_addr;
  logic [1:0] m_din;

  always @(posedge clk0) begin
    m_csb  <= sram_csb0;
    m_web  <= sram_web0;
    m_addr <= sram_addr0;
    m_din  <= sram_din0;
  end

  always @(negedge clk0) begin
    if (m_csb === 1'b0 && m_web === 1'b0) mem[m_addr] <= m_din;
    if (m_csb === 1'b0 && m_web === 1'b1) sram_dout0 <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [3:0] a, input logic [1:0] d);
    req0_valid = v;
    req0_we    = we;
    req0_addr  = a;
    req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [3:0] a, input logic [1:0] d);
    req1_valid = v;
    req1_we    = we;
    req1_addr  = a;
    req1_wdata = d;
  endtask

  task automatic solo1_write(input logic [3:0] a, input logic [1:0] d);
    drive1(1'b1, 1'b1, a, d);
    #1;
    chk("solo1_ready1", req1_ready, 1);
    chk("solo1_ready0", req0_ready, 0);
    tick();
  endtask

  initial begin
    rst0 = 1'b1;
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    drive1(1'b0, 1'b0, 4'h0, 2'b00);
    tick();
    tick();

    // Reset state, and ready held low even with valid high.
    drive0(1'b1, 1'b0, 4'h3, 2'b00);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    chk("rst_addr", sram_addr0, 0);
    chk("rst_din", sram_din0, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_rsp1_rdata", rsp1_rdata, 0);
    chk("rst_init_busy", init_busy, InitEn);
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    tick();
    rst0 = 1'b0;

`ifdef SRAM_ARB_INIT_EN
    drive0(1'b1, 1'b0, 4'hF, 2'b00);
    drive1(1'b1, 1'b0, 4'hF, 2'b00);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_busy", init_busy, 1);
      chk("init_ready0", req0_ready, 0);
      chk("init_ready1", req1_ready, 0);
      tick();
      chk("init_csb", sram_csb0, 0);
      chk("init_web", sram_web0, 0);
      chk("init_addr", sram_addr0, 8'(i));
      chk("init_din", sram_din0, 0);
    end
    #1;
    chk("init_done_busy", init_busy, 0);
    chk("init_done_ready0", req0_ready, 1);
    chk("init_done_ready1", req1_ready, 0);
    drive1(1'b0, 1'b0, 4'h0, 2'b00);
    tick();
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    tick();
    tick();
    chk("init_rd15_valid", rsp0_valid, 1);
    chk("init_rd15_data", rsp0_rdata, 0);
    tick();
`endif

    // req0 writes A=3 D=10, then reads it back.
    drive0(1'b1, 1'b1, 4'h3, 2'b10);
    #1;
    chk("wr3_ready0", req0_ready, 1);
    chk("wr3_ready1", req1_ready, 0);
    tick();
    chk("wr3_csb", sram_csb0, 0);
    chk("wr3_web", sram_web0, 0);
    chk("wr3_addr", sram_addr0, 3);
    chk("wr3_din", sram_din0, 2);
    drive0(1'b1, 1'b0, 4'h3, 2'b00);
    #1;
    chk("rd3_ready0", req0_ready, 1);
    tick();
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    chk("rd3_csb", sram_csb0, 0);
    chk("rd3_web", sram_web0, 1);
    chk("rd3_valid_t0", rsp0_valid, 0);
    tick();
    chk("rd3_valid_t1", rsp0_valid, 0);
    tick();
    chk("rd3_valid_t2", rsp0_valid, 1);
    chk("rd3_data", rsp0_rdata, 2);
    chk("rd3_rsp1_quiet", rsp1_valid, 0);
    tick();
    chk("rd3_valid_t3", rsp0_valid, 0);
    chk("rd3_csb_idle", sram_csb0, 1);

    // Seed addresses for the contention reads; req1 alone for 3 cycles.
    drive0(1'b1, 1'b1, 4'h1, 2'b01);
    tick();
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    solo1_write(4'h2, 2'b11);
    solo1_write(4'h6, 2'b10);
    solo1_write(4'h7, 2'b01);
    drive1(1'b0, 1'b0, 4'h0, 2'b00);

    // Contention: both read for 4 cycles; grants alternate starting at requester 0.
    drive0(1'b1, 1'b0, 4'h1, 2'b00);
    drive1(1'b1, 1'b0, 4'h2, 2'b00);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        #1;
        chk("cont_grant0", req0_ready, 8'(i % 2 == 0));
        chk("cont_grant1", req1_ready, 8'(i % 2 == 1));
      end
      tick();
      if (i == 3) begin
        drive0(1'b0, 1'b0, 4'h0, 2'b00);
        drive1(1'b0, 1'b0, 4'h0, 2'b00);
      end
      chk("cont_rsp0_valid", rsp0_valid, 8'(i >= 2 && i % 2 == 0));
      chk("cont_rsp1_valid", rsp1_valid, 8'(i >= 2 && i % 2 == 1));
      chk("cont_rsp_excl", 8'(rsp0_valid & rsp1_valid), 0);
      if (i >= 2 && i % 2 == 0) chk("cont_rsp0_data", rsp0_rdata, 1);
      if (i >= 2 && i % 2 == 1) chk("cont_rsp1_data", rsp1_rdata, 3);
    end

    // Write A=5 from req1, read A=5 from req0 on the very next cycle.
    drive1(1'b1, 1'b1, 4'h5, 2'b01);
    #1;
    chk("raw_wr_ready1", req1_ready, 1);
    tick();
    drive1(1'b0, 1'b0, 4'h0, 2'b00);
    drive0(1'b1, 1'b0, 4'h5, 2'b00);
    #1;
    chk("raw_rd_ready0", req0_ready, 1);
    tick();
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    tick();
    chk("raw_valid_t1", rsp0_valid, 0);
    tick();
    chk("raw_valid_t2", rsp0_valid, 1);
    chk("raw_data", rsp0_rdata, 1);
    chk("raw_rsp1_quiet", rsp1_valid, 0);

    // Read in flight, reset pulsed on the following edge: response is dropped.
    drive0(1'b1, 1'b0, 4'h3, 2'b00);
    #1;
    chk("flush_ready0", req0_ready, 1);
    tick();
    drive0(1'b0, 1'b0, 4'h0, 2'b00);
    rst0 = 1'b1;
    tick();
    chk("flush_csb_t1", sram_csb0, 1);
    chk("flush_valid_t1", rsp0_valid, 0);
    rst0 = 1'b0;
    tick();
    chk("flush_valid_t2", rsp0_valid, 0);
    chk("flush_rsp1_t2", rsp1_valid, 0);
    chk("flush_csb_t2", sram_csb0, 1);
    if (!InitEn) begin
      drive0(1'b1, 1'b0, 4'h0, 2'b00);
      drive1(1'b1, 1'b0, 4'h0, 2'b00);
      #1;
      chk("flush_ptr_grant0", req0_ready, 1);
      chk("flush_ptr_grant1", req1_ready, 0);
      tick();
      drive0(1'b0, 1'b0, 4'h0, 2'b00);
      drive1(1'b0, 1'b0, 4'h0, 2'b00);
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
